// File: rtl/level_banner_ctrl_pkg.sv
// Shared types and constants for the between-level banner controller.
package level_banner_ctrl_pkg;
  localparam int LEVEL_SIZE        = 8;
  localparam int LEVEL_MAX_DISPLAY = 99;

  typedef enum logic [2:0] {IDLE, CONVERT, SHOW, BLINK, DONE} banner_state_t;

  // Two decimal digits only, so anything above 99 is shown as 99.
  function automatic logic [6:0] sat_level(input logic [LEVEL_SIZE-1:0] lvl);
    return (lvl > LEVEL_SIZE'(LEVEL_MAX_DISPLAY)) ? 7'(LEVEL_MAX_DISPLAY) : lvl[6:0];
  endfunction
endpackage

// File: rtl/level_banner_ctrl_if.sv
// Level/frame inputs and overlay/freeze outputs of the banner controller.
interface level_banner_ctrl_if;
  import level_banner_ctrl_pkg::*;
  logic                  level_start;
  logic [LEVEL_SIZE-1:0] level_in;
  logic                  frame_tick;
  logic                  skip;
  logic [3:0]            tens_digit;
  logic [3:0]            ones_digit;
  logic                  banner_en;
  logic                  game_freeze;
  logic                  banner_done;

  modport master (output level_start, level_in, frame_tick, skip,
                  input  tens_digit, ones_digit, banner_en, game_freeze, banner_done);
  modport slave  (input  level_start, level_in, frame_tick, skip,
                  output tens_digit, ones_digit, banner_en, game_freeze, banner_done);
endinterface

// File: rtl/level_banner_ctrl_bin2bcd_seq.sv
// Iterative binary-to-two-digit BCD: subtracts 10 per cycle, no divider.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] bin_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [6:0] rem_q, rem_d;
  logic [3:0] tens_q, tens_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      tens_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      tens_q <= tens_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rem_d  = rem_q;
    tens_d = tens_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = bin_in;
      tens_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (rem_q >= 7'd10) begin
        rem_d  = rem_q - 7'd10;
        tens_d = tens_q + 4'd1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  // done is combinational so the controller can latch digits in the final step.
  assign done = busy_q && (rem_q < 7'd10);
  assign busy = busy_q;
  assign tens = tens_q;
  assign ones = rem_q[3:0];
endmodule

// File: rtl/level_banner_ctrl.sv
// Banner sequencer: latch level, convert to digits, show, blink, release gameplay.
module level_banner_ctrl
  import level_banner_ctrl_pkg::*;
#(
  parameter int SHOW_FRAMES  = 120,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_PERIOD = 8
) (
  input logic             clk,
  input logic             rst_n,
  level_banner_ctrl_if.slave bus
);
  localparam int CNT_MAX = (SHOW_FRAMES > BLINK_FRAMES)
                           ? ((SHOW_FRAMES > BLINK_PERIOD) ? SHOW_FRAMES : BLINK_PERIOD)
                           : ((BLINK_FRAMES > BLINK_PERIOD) ? BLINK_FRAMES : BLINK_PERIOD);
  localparam int CW = $clog2(CNT_MAX) + 1;

  banner_state_t state_q, state_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    tens_digit_q, tens_digit_d;
  logic [3:0]    ones_digit_q, ones_digit_d;
  logic          banner_en_q, banner_en_d;
  logic          game_freeze_q, game_freeze_d;
  logic          banner_done_q, banner_done_d;

  logic       bcd_start, bcd_busy, bcd_done;
  logic [3:0] bcd_tens, bcd_ones;

  assign bcd_start = (state_q == IDLE) && bus.level_start;

  bin2bcd_seq u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bcd_start),
    .bin_in (sat_level(bus.level_in)),
    .busy   (bcd_busy),
    .done   (bcd_done),
    .tens   (bcd_tens),
    .ones   (bcd_ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      tens_digit_q  <= '0;
      ones_digit_q  <= '0;
      banner_en_q   <= 1'b0;
      game_freeze_q <= 1'b0;
      banner_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      tens_digit_q  <= tens_digit_d;
      ones_digit_q  <= ones_digit_d;
      banner_en_q   <= banner_en_d;
      game_freeze_q <= game_freeze_d;
      banner_done_q <= banner_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    tens_digit_d = tens_digit_q;
    ones_digit_d = ones_digit_q;
    case (state_q)
      IDLE: begin
        frame_cnt_d = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (bus.level_start) state_d = CONVERT;
      end
      CONVERT: begin
        if (bcd_done) begin
          tens_digit_d = bcd_tens;
          ones_digit_d = bcd_ones;
          state_d      = SHOW;
        end else if (!bcd_busy) begin
          state_d = IDLE;
        end
      end
      SHOW: begin
        if (bus.skip) begin
          state_d = DONE;
        end else if (bus.frame_tick) begin
          if (frame_cnt_q == CW'(SHOW_FRAMES - 1)) begin
            state_d     = BLINK;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      BLINK: begin
        if (bus.skip) begin
          state_d = DONE;
        end else if (bus.frame_tick) begin
          if (frame_cnt_q == CW'(BLINK_FRAMES - 1)) begin
            state_d = DONE;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (blink_cnt_q == CW'(BLINK_PERIOD - 1)) begin
              blink_cnt_d = '0;
              phase_d     = ~phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        frame_cnt_d = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registers line up with state_q.
    banner_en_d   = (state_d == SHOW) || ((state_d == BLINK) && phase_d);
    game_freeze_d = (state_d != IDLE);
    banner_done_d = (state_d == DONE);
  end

  assign bus.tens_digit  = tens_digit_q;
  assign bus.ones_digit  = ones_digit_q;
  assign bus.banner_en   = banner_en_q;
  assign bus.game_freeze = game_freeze_q;
  assign bus.banner_done = banner_done_q;
endmodule
